// File: rtl/qsys_led_nios2_cpu_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : qsys_led_nios2_cpu_mult_seq
//  Purpose  : Sequential signed/unsigned multiplier for the Nios II datapath.
//             One SLICE_W x SLICE_W multiplier is time-shared across the slice
//             pairs of the operand magnitudes. The sign is applied at the end.
//  Option   : QSYS_LED_MULT_HI_EN enables the full product and honours in_hi.
//             When it is undefined, only the low half of the product is built.
//  Revision : 1.0 - initial release
// ============================================================================
module qsys_led_nios2_cpu_mult_seq #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_signed_a,
    input  logic              in_signed_b,
    input  logic              in_hi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              busy
);

    localparam int         c_n        = DATA_W / SLICE_W;
    localparam int         c_acc_w    = 2 * DATA_W;
    localparam int         c_prod_w   = 2 * SLICE_W;
    localparam logic [2:0] c_last_idx = 3'(c_n - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic [DATA_W-1:0]   r_out_result;
    logic [DATA_W-1:0]   r_mag_a;
    logic [DATA_W-1:0]   r_mag_b;
    logic                r_neg;
    logic [c_acc_w-1:0]  r_acc;
    logic [2:0]          r_i;
    logic [2:0]          r_j;

    logic                w_neg_a;
    logic                w_neg_b;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [SLICE_W-1:0]  w_slice_a;
    logic [SLICE_W-1:0]  w_slice_b;
    logic [c_prod_w-1:0] w_prod;
    logic [2:0]          w_sum;
    logic [c_acc_w-1:0]  w_term;
    logic [c_acc_w-1:0]  w_fixed;
    logic [DATA_W-1:0]   w_result;
    logic [2:0]          w_j_max;
    logic                w_row_end;
    logic                w_last_pair;

    // The most-negative operand negates to itself, which is its correct unsigned magnitude.
    assign w_neg_a = in_signed_a & in_a[DATA_W-1];
    assign w_neg_b = in_signed_b & in_b[DATA_W-1];
    assign w_mag_a = w_neg_a ? -in_a : in_a;
    assign w_mag_b = w_neg_b ? -in_b : in_b;

    always_comb begin
        w_slice_a = '0;
        w_slice_b = '0;
        for (int k = 0; k < c_n; k++) begin
            if (r_i == 3'(k)) w_slice_a = r_mag_a[k*SLICE_W +: SLICE_W];
            if (r_j == 3'(k)) w_slice_b = r_mag_b[k*SLICE_W +: SLICE_W];
        end
    end

    assign w_prod = c_prod_w'(w_slice_a) * c_prod_w'(w_slice_b);
    assign w_sum  = r_i + r_j;

    always_comb begin
        w_term = '0;
        for (int s = 0; s <= 2*c_n-2; s++) begin
            if (w_sum == 3'(s)) w_term = c_acc_w'(w_prod) << (s * SLICE_W);
        end
    end

    assign w_fixed = r_neg ? -r_acc : r_acc;

`ifdef QSYS_LED_MULT_HI_EN
    logic r_hi;

    assign w_j_max  = c_last_idx;
    assign w_result = r_hi ? w_fixed[c_acc_w-1:DATA_W] : w_fixed[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 1'b0;
        end else if (r_state == ST_IDLE && in_valid) begin
            r_hi <= in_hi;
        end
    end
`else
    logic w_unused_hi;

    // Pairs with i+j >= N only touch the upper half, so each row stops early.
    assign w_j_max     = c_last_idx - r_i;
    assign w_result    = w_fixed[DATA_W-1:0];
    assign w_unused_hi = in_hi;
`endif

    assign w_row_end   = (r_j == w_j_max);
    assign w_last_pair = w_row_end && (r_i == c_last_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_out_result <= '0;
            r_mag_a      <= '0;
            r_mag_b      <= '0;
            r_neg        <= 1'b0;
            r_acc        <= '0;
            r_i          <= '0;
            r_j          <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mag_a    <= w_mag_a;
                        r_mag_b    <= w_mag_b;
                        r_neg      <= w_neg_a ^ w_neg_b;
                        r_acc      <= '0;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc <= r_acc + w_term;
                    if (w_last_pair) begin
                        r_state <= ST_FIX;
                    end else if (w_row_end) begin
                        r_i <= r_i + 3'd1;
                        r_j <= '0;
                    end else begin
                        r_j <= r_j + 3'd1;
                    end
                end
                ST_FIX: begin
                    r_acc        <= w_fixed;
                    r_out_result <= w_result;
                    r_out_valid  <= 1'b1;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign out_result = r_out_result;

endmodule
`default_nettype wire
